// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the pipeline and the HI/LO multiply-divide unit
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative HI/LO multiply/divide unit; divider present only with MULDIV_DIV_EN
// 32 shift-add or restoring iterations on magnitudes, then one FIX cycle applies signs and writes HI/LO.
module muldiv (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd3} state_t;
`endif

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic        neg_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef MULDIV_DIV_EN
  logic        neg_r;
  logic        is_div;
  logic        dz;
`endif

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  logic        sgn_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        sign_diff;

`ifdef MULDIV_DIV_EN
  assign sgn_in = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`else
  assign sgn_in = (bus.op == OP_MULT);
`endif
  assign a_mag     = mag(bus.rs_data, sgn_in);
  assign b_mag     = mag(bus.rt_data, sgn_in);
  assign sign_diff = sgn_in && (bus.rs_data[31] ^ bus.rt_data[31]);

  // acc holds {partial product, remaining multiplier bits}; shift right one bit per step
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

`ifdef MULDIV_DIV_EN
  // acc holds {partial remainder, dividend bits / quotient bits}; shift left one bit per step
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  assign div_ge   = acc[63:31] >= {1'b0, opb};
  assign div_sub  = acc[62:31] - opb;
  assign div_next = div_ge ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
`endif

  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    prod_fix = neg_q ? (~acc + 64'd1) : acc;
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      fix_lo = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
      fix_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opb    <= 32'd0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                acc    <= {32'd0, b_mag};
                opb    <= a_mag;
                neg_q  <= sign_diff;
                cnt    <= 5'd0;
                busy_q <= 1'b1;
                state  <= S_MUL;
`ifdef MULDIV_DIV_EN
                is_div <= 1'b0;
                neg_r  <= 1'b0;
                dz     <= 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: begin
                cnt    <= 5'd0;
                busy_q <= 1'b1;
                is_div <= 1'b1;
                opb    <= b_mag;
                state  <= S_DIV;
                // divide by zero parks the final answer in acc and freezes it
                if (bus.rt_data == 32'd0) begin
                  dz    <= 1'b1;
                  acc   <= {bus.rs_data, 32'hFFFF_FFFF};
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                end else begin
                  dz    <= 1'b0;
                  acc   <= {32'd0, a_mag};
                  neg_q <= sign_diff;
                  neg_r <= sgn_in && bus.rs_data[31];
                end
              end
`endif
              OP_MTHI: hi_q <= bus.rs_data;
              OP_MTLO: lo_q <= bus.rs_data;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          if (!dz) acc <= div_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
`endif
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - directed vector bench for muldiv; division vectors only when MULDIV_DIV_EN is defined
module tb_muldiv;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_if bus ();

  muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.rs_data = a;
    bus.rt_data = b;
    step();
    bus.start   = 1'b0;
    bus.op      = 3'($urandom);
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  // called right after the accept edge; n counts cycles after that edge
  task automatic wait_done(output int done_at, output int busy_n, output bit held);
    logic [31:0] h0;
    logic [31:0] l0;
    h0      = bus.hi;
    l0      = bus.lo;
    done_at = -1;
    busy_n  = 0;
    held    = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (bus.busy) busy_n++;
      if (bus.busy && (bus.hi !== h0 || bus.lo !== l0)) held = 1'b0;
      if (bus.done) begin
        done_at = n;
        break;
      end
      step();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d;
    int b;
    bit h;
    issue(v.op, v.rs, v.rt);
    wait_done(d, b, h);
    chk({v.name, " latency"}, 64'(d), 64'd34);
    chk({v.name, " busy_cycles"}, 64'(b), 64'd33);
    chk({v.name, " held"}, 64'(h), 64'd1);
    chk({v.name, " hi"}, 64'(bus.hi), 64'(v.exp_hi));
    chk({v.name, " lo"}, 64'(bus.lo), 64'(v.exp_lo));
  endtask

  // ignored request: no busy, no done, hi/lo untouched
  task automatic check_ignored(input string name, input logic [2:0] o);
    logic [31:0] h0;
    logic [31:0] l0;
    bit          seen;
    h0 = bus.hi;
    l0 = bus.lo;
    issue(o, 32'd100, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy || bus.done) seen = 1'b1;
      step();
    end
    chk({name, " no_activity"}, 64'(seen), 64'd0);
    chk({name, " hi_lo"}, {bus.hi, bus.lo}, {h0, l0});
  endtask

  initial begin
    int  d;
    int  b;
    bit  h;
    bit  seen;

    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;

    vecs.push_back('{"multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_m7x6", 3'b000, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6});
    vecs.push_back('{"mult_min_sq", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"multu_2p31x2", 3'b001, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000});
    vecs.push_back('{"mult_m1xm1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
    vecs.push_back('{"mult_3x5", 3'b000, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{"div_m7d2", 3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{"divu_100d0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF});
    vecs.push_back('{"div_7dm2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{"divu_max_d10", 3'b011, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999});
    vecs.push_back('{"div_m7d0", 3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF});
`endif

    #12;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // MTHI / MTLO write at the accept edge without going busy
    issue(3'b100, 32'h12345678, 32'd0);
    chk("mthi hi", 64'(bus.hi), 64'h12345678);
    chk("mthi busy", 64'(bus.busy), 64'd0);
    issue(3'b101, 32'hCAFEF00D, 32'd0);
    chk("mtlo lo", 64'(bus.lo), 64'hCAFEF00D);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy || bus.done) seen = 1'b1;
      step();
    end
    chk("mt no_activity", 64'(seen), 64'd0);

    check_ignored("op110", 3'b110);
`ifndef MULDIV_DIV_EN
    check_ignored("divu_disabled", 3'b011);
    check_ignored("div_disabled", 3'b010);
`endif

    // start while busy must be dropped
    issue(3'b001, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) step();
    bus.start   = 1'b1;
    bus.op      = 3'b100;
    bus.rs_data = 32'hDEADBEEF;
    step();
    bus.op      = 3'b000;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd9;
    step();
    bus.start = 1'b0;
    wait_done(d, b, h);
    chk("busy_start latency", 64'(d), 64'd27);
    chk("busy_start result", {bus.hi, bus.lo}, {32'd0, 32'd12});
    step();
    chk("busy_start no_rerun", 64'(bus.busy), 64'd0);

    // back-to-back: second start issued in the done cycle
    issue(3'b001, 32'd6, 32'd7);
    wait_done(d, b, h);
    chk("b2b first lo", 64'(bus.lo), 64'd42);
    issue(3'b000, 32'hFFFFFFFE, 32'd5);
    wait_done(d, b, h);
    chk("b2b second latency", 64'(d), 64'd34);
    chk("b2b second busy_cycles", 64'(b), 64'd33);
    chk("b2b second result", {bus.hi, bus.lo}, {32'hFFFFFFFF, 32'hFFFFFFF6});

    // reset at iteration 10 aborts without touching hi/lo afterwards
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort hi_lo", {bus.hi, bus.lo}, 64'd0);
    #2;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      step();
    end
    chk("abort no_done", 64'(seen), 64'd0);
    chk("abort hi_lo_after", {bus.hi, bus.lo}, 64'd0);

    // first edge after reset release accepts a start
    rst = 1'b0;
    #2;
    rst = 1'b1;
    issue(3'b001, 32'd11, 32'd13);
    wait_done(d, b, h);
    chk("post_reset latency", 64'(d), 64'd34);
    chk("post_reset lo", 64'(bus.lo), 64'd143);
    step();
    chk("done one_cycle", 64'(bus.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001: The module SHALL expose these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  request strobe; sampled on rising clk.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- rs_data  input  32  first operand (multiplicand / dividend / MTHI/MTLO source), fed from register-file port 1.
- rt_data  input  32  second operand (multiplier / divisor), fed from register-file port 2.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle completion pulse.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Function
REQ-002: States SHALL be IDLE, MUL, DIV, FIX, with no other reachable state.
REQ-003: start SHALL be accepted only in IDLE with a valid op.
- start is ignored while busy=1.
- start with op 110 or 111 is ignored.
REQ-004: On an accepted MTHI or MTLO:
- hi (MTHI) or lo (MTLO) loads rs_data at that same edge.
- State stays IDLE; busy and done stay 0.
REQ-005: On an accepted MULT/MULTU/DIV/DIVU, rs_data, rt_data and signedness SHALL be captured at the accept edge; later input changes have no effect.
REQ-006: MULT/MULTU SHALL use radix-2 shift-add on operand magnitudes; DIV/DIVU SHALL use radix-2 restoring division on operand magnitudes; each takes exactly 32 iteration cycles, then 1 FIX cycle.
REQ-007: FIX SHALL apply the result signs and write hi and lo at the FIX exit edge.
REQ-008: Multiply result SHALL be the 64-bit product: hi = bits 63:32, lo = bits 31:0.
- MULT: two's-complement signed.
- MULTU: unsigned.
REQ-009: Divide result SHALL be lo = quotient, hi = remainder.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-010: Divide by zero (DIV or DIVU) SHALL complete with normal latency: lo = 32'hFFFFFFFF, hi = rs_data.
REQ-011: DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo = 32'h80000000, hi = 0.
REQ-012: busy SHALL be 1 for exactly 33 cycles, starting the cycle after the accept edge.
REQ-013: done SHALL be 1 for exactly one cycle, the first cycle after busy falls; the new hi/lo are visible in that cycle.
REQ-014: hi and lo SHALL hold their previous values throughout busy, because iteration uses internal registers only.
REQ-015: A start in the done cycle SHALL be accepted, giving back-to-back operations with no bubble.
REQ-016: Total latency SHALL be 34 cycles from the accept edge to the done cycle.

Reset
REQ-017: While rst=0, the module SHALL force: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, all internal registers = 0.
REQ-018: Reset asserted mid-operation SHALL abort the operation with no partial hi/lo update.
REQ-019: The first start SHALL be accepted on the first rising clk after rst deasserts.

Configuration
REQ-020: With the macro MULDIV_DIV_EN defined, all of the operations above SHALL be implemented.
REQ-021: Without MULDIV_DIV_EN:
- The DIV state and divider datapath SHALL be absent.
- op 010 and 011 SHALL be ignored like op 110 (no busy, no done, hi/lo unchanged).
- Multiply and MTHI/MTLO behaviour SHALL be unchanged.

Verification
REQ-022: The bench SHALL cover these directed scenarios:
- MULTU: rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> done at accept+34 cycles; hi=32'hFFFFFFFE, lo=32'h00000001; busy high exactly 33 cycles.
- MULT: rs=-7, rt=6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6.
- DIV: rs=-7, rt=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIV (MULDIV_DIV_EN defined): rs=32'h80000000, rt=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIVU (MULDIV_DIV_EN defined): rs=100, rt=0 -> lo=32'hFFFFFFFF, hi=100.
- Control cases:
  - MTHI rs=32'h12345678 -> hi updates next edge, busy never asserts.
  - start during busy -> ignored.
  - rst pulsed at iteration 10 -> busy=0, hi=lo=0, no done.
  - start in the done cycle -> second op completes 34 cycles later.
- MULDIV_DIV_EN undefined: DIVU start -> busy stays 0, hi/lo unchanged.
